// File: rtl/sevenseg_scan_driver_if.sv
// Digit/adjust inputs and active-low display outputs of the
// seven-segment scan driver, bundled as one port.
interface sevenseg_scan_driver_if;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       adj_en;
  logic       adj_sel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output min_tens,
    output min_ones,
    output sec_tens,
    output sec_ones,
    output adj_en,
    output adj_sel,
    input  seg,
    input  an,
    input  dp
  );

  modport slave (
    input  min_tens,
    input  min_ones,
    input  sec_tens,
    input  sec_ones,
    input  adj_en,
    input  adj_sel,
    output seg,
    output an,
    output dp
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Four-digit MM.SS common-anode scan driver with
// adjust-mode pair blinking; all outputs registered.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic             clk,
  input logic             reset,
  sevenseg_scan_driver_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ?
    $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ?
    $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    digit_idx;
  logic          blink_phase;

  logic [3:0] digit;
  logic [6:0] seg_d;
  logic [3:0] an_d;
  logic       dp_d;
  logic       in_pair;
  logic       blank;

  always_comb begin
    digit = bus.sec_ones;
    an_d  = 4'b1110;
    unique case (digit_idx)
      2'd0: begin
        digit = bus.sec_ones;
        an_d  = 4'b1110;
      end
      2'd1: begin
        digit = bus.sec_tens;
        an_d  = 4'b1101;
      end
      2'd2: begin
        digit = bus.min_ones;
        an_d  = 4'b1011;
      end
      2'd3: begin
        digit = bus.min_tens;
        an_d  = 4'b0111;
      end
      default: begin
        digit = bus.sec_ones;
        an_d  = 4'b1110;
      end
    endcase
  end

  always_comb begin
    seg_d = 7'b1111111;
    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end

  // adj_sel=1 picks the seconds pair (idx0/1), 0 the minutes pair
  always_comb begin
    in_pair = bus.adj_sel ? ~digit_idx[1] : digit_idx[1];
    blank   = bus.adj_en & blink_phase & in_pair;
    dp_d    = (digit_idx != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      bus.an      <= 4'b1111;
      bus.seg     <= 7'b1111111;
      bus.dp      <= 1'b1;
    end else begin
      if (refresh_cnt == RMAX) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      if (blink_cnt == BMAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      if (blank) begin
        bus.an  <= 4'b1111;
        bus.seg <= 7'b1111111;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= an_d;
        bus.seg <= seg_d;
        bus.dp  <= dp_d;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with
// REFRESH_DIV=4 and BLINK_DIV=16.
module tb_sevenseg_scan_driver;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sevenseg_scan_driver_if bus();

  sevenseg_scan_driver #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [0:15];
  logic [3:0] antab  [0:3];
  logic [3:0] digs   [0:3];

  initial begin
    segtab[0]  = 7'b1000000;
    segtab[1]  = 7'b1111001;
    segtab[2]  = 7'b0100100;
    segtab[3]  = 7'b0110000;
    segtab[4]  = 7'b0011001;
    segtab[5]  = 7'b0010010;
    segtab[6]  = 7'b0000010;
    segtab[7]  = 7'b1111000;
    segtab[8]  = 7'b0000000;
    segtab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++)
      segtab[i] = 7'b1111111;
    antab[0] = 4'b1110;
    antab[1] = 4'b1101;
    antab[2] = 4'b1011;
    antab[3] = 4'b0111;
    digs[0] = 4'd4;
    digs[1] = 4'd3;
    digs[2] = 4'd2;
    digs[3] = 4'd1;
  end

  task automatic set_digits();
    bus.sec_ones = digs[0];
    bus.sec_tens = digs[1];
    bus.min_ones = digs[2];
    bus.min_tens = digs[3];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_digits();
    bus.adj_en  = 1'b0;
    bus.adj_sel = 1'b0;
    do_reset();
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111
        || bus.dp !== 1'b1) begin
      errors++;
      $display("FAIL reset: an=%b seg=%b dp=%b want 1111 1111111 1",
               bus.an, bus.seg, bus.dp);
    end
  endtask

  task automatic test_scan();
    int idx;
    logic [6:0] es;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      idx = ((k - 1) / 4) % 4;
      es  = segtab[digs[idx]];
      checks++;
      if (bus.an !== antab[idx] || bus.seg !== es
          || bus.dp !== (idx != 2)) begin
        errors++;
        $display("FAIL scan k=%0d: an=%b seg=%b dp=%b want %b %b %b",
                 k, bus.an, bus.seg, bus.dp,
                 antab[idx], es, (idx != 2));
      end
    end
  endtask

  task automatic test_decode();
    for (int v = 0; v < 16; v++) begin
      bus.sec_ones = 4'(v);
      do_reset();
      @(negedge clk);
      checks++;
      if (bus.an !== 4'b1110 || bus.seg !== segtab[v]) begin
        errors++;
        $display("FAIL decode v=%0d: an=%b seg=%b want 1110 %b",
                 v, bus.an, bus.seg, segtab[v]);
      end
      bus.sec_ones = 4'(15 - v);
      @(negedge clk);
      checks++;
      if (bus.seg !== segtab[15 - v]) begin
        errors++;
        $display("FAIL midslot v=%0d: seg=%b want %b",
                 15 - v, bus.seg, segtab[15 - v]);
      end
    end
    set_digits();
  endtask

  task automatic test_blink(input logic sel);
    int idx;
    int ph;
    logic bl;
    logic [3:0] ea;
    bus.adj_en  = 1'b1;
    bus.adj_sel = sel;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      idx = ((k - 1) / 4) % 4;
      ph  = ((k - 1) / 16) % 2;
      bl  = (ph == 1) && (sel ? (idx < 2) : (idx >= 2));
      ea  = bl ? 4'b1111 : antab[idx];
      checks++;
      if (bus.an !== ea || bus.dp !== (!bl && idx == 2)
          ? 1'b0 : 1'b1) begin
      end
      if (bus.an !== ea) begin
        errors++;
        $display("FAIL blink sel=%0b k=%0d: an=%b want %b",
                 sel, k, bus.an, ea);
      end
      if (bl && bus.seg !== 7'b1111111) begin
        errors++;
        $display("FAIL blinkseg sel=%0b k=%0d: seg=%b want 1111111",
                 sel, k, bus.seg);
      end
    end
    bus.adj_en = 1'b0;
  endtask

  task automatic test_adj_off();
    int idx;
    bus.adj_en  = 1'b0;
    bus.adj_sel = 1'b1;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      idx = ((k - 1) / 4) % 4;
      checks++;
      if (bus.an !== antab[idx]) begin
        errors++;
        $display("FAIL adj_off k=%0d: an=%b want %b",
                 k, bus.an, antab[idx]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 9; k++)
      @(negedge clk);
    checks++;
    if (bus.an !== 4'b1011 || bus.dp !== 1'b0) begin
      errors++;
      $display("FAIL midpre: an=%b dp=%b want 1011 0",
               bus.an, bus.dp);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111
        || bus.dp !== 1'b1) begin
      errors++;
      $display("FAIL midreset: an=%b seg=%b dp=%b want 1111 1111111 1",
               bus.an, bus.seg, bus.dp);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== antab[(k - 1) / 4]) begin
        errors++;
        $display("FAIL restart k=%0d: an=%b want %b",
                 k, bus.an, antab[(k - 1) / 4]);
      end
    end
  endtask

  task automatic test_onehot();
    logic ok;
    bus.adj_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      bus.adj_sel = ((k / 50) % 2) == 1;
      @(negedge clk);
      ok = (bus.an == 4'b1111) || ($countones(~bus.an) == 1);
      ok = ok && ((bus.dp == 1'b0) == (bus.an == 4'b1011));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL onehot k=%0d: an=%b dp=%b want onehot/dp rule",
                 k, bus.an, bus.dp);
      end
    end
    bus.adj_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    test_reset();
    test_scan();
    test_decode();
    test_blink(1'b1);
    test_blink(1'b0);
    test_adj_off();
    test_reset_mid();
    test_onehot();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
